// File: rtl/micro_sequencer.sv
// Micro-program counter controller: picks the next control-store address each cycle
// (increment, branch, dispatch, conditional branch, one-deep call/return) and owns run/idle/halt.
module micro_sequencer #(
  parameter int AW         = 8,
  parameter int FETCH_ADDR = 0,
  parameter int MAP_MAX    = 75
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stall,
  input  logic [2:0]    next_op,
  input  logic [AW-1:0] br_addr,
  input  logic [15:0]   map_addr,
  input  logic          z_flag,
  output logic [AW-1:0] upc,
  output logic          rom_en,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_INC  = 3'd0,
    OP_JMP  = 3'd1,
    OP_MAP  = 3'd2,
    OP_BZ   = 3'd3,
    OP_BNZ  = 3'd4,
    OP_CALL = 3'd5,
    OP_RET  = 3'd6,
    OP_END  = 3'd7
  } op_t;

  localparam logic [AW-1:0] FETCH   = AW'(FETCH_ADDR);
  localparam logic [AW-1:0] UPC_MAX = {AW{1'b1}};

  state_t        state_r, state_nxt;
  logic [AW-1:0] upc_r, upc_nxt;
  logic [AW-1:0] ret_addr_r, ret_addr_nxt;
  logic          ret_vld_r, ret_vld_nxt;
  logic          rom_en_r, busy_r, done_r, err_r;
  logic          done_nxt, err_nxt;

  op_t           op_s;
  logic [AW-1:0] upc_inc_s;
  logic          at_max_s;
  logic [31:0]   map_wide_s;
  logic          map_ok_s;

  assign op_s       = op_t'(next_op);
  assign upc_inc_s  = upc_r + AW'(1);
  assign at_max_s   = (upc_r == UPC_MAX);
  // Dispatch target must fit both the legal map range and the upc width.
  assign map_wide_s = {16'd0, map_addr};
  assign map_ok_s   = (map_wide_s <= 32'(MAP_MAX)) && (map_wide_s < (32'd1 << AW));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      upc_r      <= FETCH;
      ret_addr_r <= {AW{1'b0}};
      ret_vld_r  <= 1'b0;
      rom_en_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      upc_r      <= upc_nxt;
      ret_addr_r <= ret_addr_nxt;
      ret_vld_r  <= ret_vld_nxt;
      rom_en_r   <= (state_nxt == ST_RUN);
      busy_r     <= (state_nxt == ST_RUN);
      done_r     <= done_nxt;
      err_r      <= err_nxt;
    end
  end

  // Faults leave upc and the return register untouched so the faulting address stays visible.
  always_comb begin
    state_nxt    = state_r;
    upc_nxt      = upc_r;
    ret_addr_nxt = ret_addr_r;
    ret_vld_nxt  = ret_vld_r;
    done_nxt     = 1'b0;
    err_nxt      = err_r;
    case (state_r)
      ST_IDLE: begin
        upc_nxt = FETCH;
        if (start) begin
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stall) begin
          state_nxt = ST_RUN;
        end else begin
          case (op_s)
            OP_INC: begin
              if (at_max_s) begin
                state_nxt = ST_HALT;
                err_nxt   = 1'b1;
              end else begin
                upc_nxt = upc_inc_s;
              end
            end
            OP_JMP: begin
              upc_nxt = br_addr;
            end
            OP_MAP: begin
              if (map_ok_s) begin
                upc_nxt = map_addr[AW-1:0];
              end else begin
                state_nxt = ST_HALT;
                err_nxt   = 1'b1;
              end
            end
            OP_BZ, OP_BNZ: begin
              if (z_flag == (op_s == OP_BZ)) begin
                upc_nxt = br_addr;
              end else if (at_max_s) begin
                state_nxt = ST_HALT;
                err_nxt   = 1'b1;
              end else begin
                upc_nxt = upc_inc_s;
              end
            end
            OP_CALL: begin
              if (ret_vld_r) begin
                state_nxt = ST_HALT;
                err_nxt   = 1'b1;
              end else begin
                ret_addr_nxt = upc_inc_s;
                ret_vld_nxt  = 1'b1;
                upc_nxt      = br_addr;
              end
            end
            OP_RET: begin
              if (ret_vld_r) begin
                upc_nxt     = ret_addr_r;
                ret_vld_nxt = 1'b0;
              end else begin
                state_nxt = ST_HALT;
                err_nxt   = 1'b1;
              end
            end
            OP_END: begin
              upc_nxt   = FETCH;
              done_nxt  = 1'b1;
              state_nxt = ST_IDLE;
            end
            default: begin
              state_nxt = ST_HALT;
              err_nxt   = 1'b1;
            end
          endcase
        end
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt = ST_HALT;
        err_nxt   = 1'b1;
      end
    endcase
  end

  assign upc    = upc_r;
  assign rom_en = rom_en_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign err    = err_r;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: stimulus queues expected post-edge state,
// a negedge monitor pops and compares it.
module tb_micro_sequencer;

  localparam logic [2:0] INC = 3'd0, JMP = 3'd1, MAP = 3'd2, BZ = 3'd3,
                         BNZ = 3'd4, CALL = 3'd5, RET = 3'd6, ENDO = 3'd7;

  logic        clk, rst_n, start, stall, z_flag;
  logic [2:0]  next_op;
  logic [7:0]  br_addr, upc;
  logic [15:0] map_addr;
  logic        rom_en, busy, done, err;

  typedef struct {
    int          tgt;
    logic [11:0] v;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   cyc_cnt = 0;
  int   total = 0;
  int   bad = 0;

  micro_sequencer #(.AW(8), .FETCH_ADDR(0), .MAP_MAX(75)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .next_op(next_op),
    .br_addr(br_addr), .map_addr(map_addr), .z_flag(z_flag), .upc(upc),
    .rom_en(rom_en), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] want);
    total = total + 1;
    if (act !== want) begin
      bad = bad + 1;
      $display("FAIL %s: got upc=%0d rom_en/busy/done/err=%b, expected upc=%0d rom_en/busy/done/err=%b",
               nm, act[11:4], act[3:0], want[11:4], want[3:0]);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].tgt <= cyc_cnt) begin
      e = sb.pop_front();
      chk(e.nm, {upc, rom_en, busy, done, err}, e.v);
    end
  end

  task automatic step(input logic st, input logic sl, input logic [2:0] op,
                      input logic [7:0] br, input logic [15:0] ma, input logic z,
                      input logic [7:0] e_upc, input logic e_rom, input logic e_busy,
                      input logic e_done, input logic e_err, input string nm);
    exp_t e;
    start = st; stall = sl; next_op = op; br_addr = br; map_addr = ma; z_flag = z;
    e.tgt = cyc_cnt + 1;
    e.v   = {e_upc, e_rom, e_busy, e_done, e_err};
    e.nm  = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    total = total + 1;
    if (sb.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic reset_pulse();
    drain();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; next_op = INC;
    br_addr = 8'd0; map_addr = 16'd0; z_flag = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, INC, 8'd0, 16'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
    rst_n = 1'b1;
    step(1'b0, 1'b1, INC, 8'd0, 16'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "idle_hold");
    step(1'b1, 1'b0, INC, 8'd0, 16'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, "start");
    step(1'b0, 1'b0, INC, 8'd0, 16'd0, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, "inc1");
    step(1'b0, 1'b0, INC, 8'd0, 16'd0, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0, "inc2");
    step(1'b0, 1'b0, INC, 8'd0, 16'd0, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0, "inc3");
    step(1'b0, 1'b0, MAP, 8'd0, 16'd45, 1'b0, 8'd45, 1'b1, 1'b1, 1'b0, 1'b0, "map45");
    step(1'b0, 1'b0, MAP, 8'd0, 16'd75, 1'b0, 8'd75, 1'b1, 1'b1, 1'b0, 1'b0, "map_max");
    step(1'b0, 1'b0, JMP, 8'd10, 16'd0, 1'b0, 8'd10, 1'b1, 1'b1, 1'b0, 1'b0, "jmp10");
    step(1'b0, 1'b0, BZ, 8'd66, 16'd0, 1'b1, 8'd66, 1'b1, 1'b1, 1'b0, 1'b0, "bz_taken");
    step(1'b0, 1'b0, BZ, 8'd66, 16'd0, 1'b0, 8'd67, 1'b1, 1'b1, 1'b0, 1'b0, "bz_fall");
    step(1'b0, 1'b0, BNZ, 8'd30, 16'd0, 1'b0, 8'd30, 1'b1, 1'b1, 1'b0, 1'b0, "bnz_taken");
    step(1'b0, 1'b0, BNZ, 8'd30, 16'd0, 1'b1, 8'd31, 1'b1, 1'b1, 1'b0, 1'b0, "bnz_fall");
    step(1'b0, 1'b0, JMP, 8'd58, 16'd0, 1'b0, 8'd58, 1'b1, 1'b1, 1'b0, 1'b0, "jmp58");
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, JMP, 8'd99, 16'd0, 1'b0, 8'd58, 1'b1, 1'b1, 1'b0, 1'b0, "stall");
    step(1'b0, 1'b0, ENDO, 8'd0, 16'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, "end");
    step(1'b0, 1'b0, JMP, 8'd99, 16'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "done_pulse");

    step(1'b1, 1'b1, INC, 8'd0, 16'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, "start2");
    step(1'b0, 1'b0, JMP, 8'd5, 16'd0, 1'b0, 8'd5, 1'b1, 1'b1, 1'b0, 1'b0, "jmp5");
    step(1'b0, 1'b0, CALL, 8'd20, 16'd0, 1'b0, 8'd20, 1'b1, 1'b1, 1'b0, 1'b0, "call");
    step(1'b0, 1'b0, RET, 8'd0, 16'd0, 1'b0, 8'd6, 1'b1, 1'b1, 1'b0, 1'b0, "ret");
    step(1'b0, 1'b0, RET, 8'd0, 16'd0, 1'b0, 8'd6, 1'b0, 1'b0, 1'b0, 1'b1, "ret_empty");
    step(1'b1, 1'b0, JMP, 8'd1, 16'd0, 1'b0, 8'd6, 1'b0, 1'b0, 1'b0, 1'b1, "halt_hold");

    reset_pulse();
    step(1'b1, 1'b0, INC, 8'd0, 16'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, "restart");
    step(1'b0, 1'b0, JMP, 8'd37, 16'd0, 1'b0, 8'd37, 1'b1, 1'b1, 1'b0, 1'b0, "jmp37");
    drain();
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {upc, rom_en, busy, done, err}, 12'h000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    step(1'b1, 1'b0, INC, 8'd0, 16'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, "start3");
    step(1'b0, 1'b0, CALL, 8'd40, 16'd0, 1'b0, 8'd40, 1'b1, 1'b1, 1'b0, 1'b0, "call40");
    step(1'b0, 1'b0, CALL, 8'd50, 16'd0, 1'b0, 8'd40, 1'b0, 1'b0, 1'b0, 1'b1, "call_nest");

    reset_pulse();
    step(1'b1, 1'b0, INC, 8'd0, 16'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, "start4");
    step(1'b0, 1'b0, JMP, 8'd12, 16'd0, 1'b0, 8'd12, 1'b1, 1'b1, 1'b0, 1'b0, "jmp12");
    step(1'b0, 1'b0, MAP, 8'd0, 16'd200, 1'b0, 8'd12, 1'b0, 1'b0, 1'b0, 1'b1, "map200");

    reset_pulse();
    step(1'b1, 1'b0, INC, 8'd0, 16'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, "start5");
    step(1'b0, 1'b0, MAP, 8'd0, 16'd76, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, "map76");

    reset_pulse();
    step(1'b1, 1'b0, INC, 8'd0, 16'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, "start6");
    step(1'b0, 1'b0, JMP, 8'd255, 16'd0, 1'b0, 8'd255, 1'b1, 1'b1, 1'b0, 1'b0, "jmp255");
    step(1'b0, 1'b0, BZ, 8'd7, 16'd0, 1'b1, 8'd7, 1'b1, 1'b1, 1'b0, 1'b0, "bz_at_max");
    step(1'b0, 1'b0, JMP, 8'd255, 16'd0, 1'b0, 8'd255, 1'b1, 1'b1, 1'b0, 1'b0, "jmp255b");
    step(1'b0, 1'b0, INC, 8'd0, 16'd0, 1'b0, 8'd255, 1'b0, 1'b0, 1'b0, 1'b1, "inc_max");

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
